// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file: clear-sequencer
// state encoding and default geometry, also consumed by the core's hazard unit.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port forwarding mux: picks the highest-indexed write port hitting the
// read address this cycle, otherwise passes the stored value through.
module regfile_bypass #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]       ra,
  input  logic [XLEN-1:0]     rd_mem,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NWR-1:0]      we,
  input  logic                wr_ready,
  output logic [XLEN-1:0]     rd
);

  // Later ports overwrite earlier hits, so the highest index wins.
  always_comb begin
    rd = rd_mem;
    for (int j = 0; j < NWR; j++) begin
      if ((BYPASS != 0) && wr_ready && we[j] && (ra != '0) &&
          (wa[j*AW +: AW] == ra)) begin
        rd = wd[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, synchronous writes,
// optional same-cycle bypass and a one-register-per-cycle clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int AW     = $clog2(NREG),
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NWR-1:0]      we,
  output logic                wr_ready,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  clr_state_e      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [AW-1:0]   wa_a [NWR];
  logic [XLEN-1:0] wd_a [NWR];
  logic            clear_active;

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wunpack
      assign wa_a[gi] = wa[gi*AW +: AW];
      assign wd_a[gi] = wd[gi*XLEN +: XLEN];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_ready     = (state_q == ST_IDLE);
  assign clr_busy     = (state_q != ST_IDLE);
  assign clr_done     = (state_q == ST_DONE);
  assign clear_active = (state_q == ST_CLEAR);

  // Port writes and the clear sequencer never coincide, since wr_ready is low in CLEAR.
  always_comb begin
    mem_d = mem_q;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ready && we[j] && (wa_a[j] == AW'(r))) begin
          mem_d[r] = wd_a[j];
        end
      end
      if (clear_active && (cnt_q == AW'(r))) begin
        mem_d[r] = '0;
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra_i;
      logic [XLEN-1:0] rd_byp;

      assign ra_i = ra[gi*AW +: AW];

      regfile_bypass #(
        .XLEN  (XLEN),
        .AW    (AW),
        .NWR   (NWR),
        .BYPASS(BYPASS)
      ) u_bypass (
        .ra      (ra_i),
        .rd_mem  (mem_q[ra_i]),
        .wa      (wa),
        .wd      (wd),
        .we      (we),
        .wr_ready(wr_ready),
        .rd      (rd_byp)
      );

      // Outputs are forced low while reset is held, even if a bypass would hit.
      assign rd[gi*XLEN +: XLEN] = rst ? rd_byp : '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (XLEN=32, NREG=32, NRD=2, NWR=2, BYPASS=1).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  localparam int K_RD0  = 0;
  localparam int K_RD1  = 1;
  localparam int K_WRDY = 2;
  localparam int K_BUSY = 3;
  localparam int K_DONE = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NWR-1:0]      we;
  logic                wr_ready;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  typedef struct {
    int           kind;
    logic [31:0]  exp;
    logic [127:0] name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic [31:0] act;
  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .wa(wa), .wd(wd), .we(we),
    .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  // Monitor: drains every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      case (cur.kind)
        K_RD0:   act = rd[31:0];
        K_RD1:   act = rd[63:32];
        K_WRDY:  act = {31'b0, wr_ready};
        K_BUSY:  act = {31'b0, clr_busy};
        default: act = {31'b0, clr_done};
      endcase
      n_checks++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %0s: got %h expected %h", cur.name, act, cur.exp);
      end else begin
        $display("ok   %0s: %h", cur.name, act);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input int kind, input logic [31:0] e, input logic [127:0] nm);
    exp_t x;
    x.kind = kind;
    x.exp  = e;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_w(input int p, input int a, input logic [31:0] d);
    wa[p*AW +: AW]     = AW'(a);
    wd[p*XLEN +: XLEN] = d;
  endtask

  task automatic fill_all();
    we = 2'b01;
    for (int r = 1; r < NREG; r++) begin
      set_w(0, r, 32'(r));
      step();
    end
    we = 2'b00;
  endtask

  initial begin
    rst = 1'b0; ra = '0; wa = '0; wd = '0; we = '0; clr_req = 1'b0;
    step();

    // Reset held: reads and bypass are masked.
    set_ra(0, 5); set_ra(1, 0);
    we = 2'b01; set_w(0, 5, 32'h1234_5678);
    expect_v(K_RD0, 32'h0, "rst_rd0");
    expect_v(K_WRDY, 32'h1, "rst_wrdy");
    expect_v(K_BUSY, 32'h0, "rst_busy");
    expect_v(K_DONE, 32'h0, "rst_done");
    step();
    we = 2'b00; rst = 1'b1;
    for (int a = 0; a < NREG; a++) begin
      set_ra(0, a); set_ra(1, NREG - 1 - a);
      expect_v(K_RD0, 32'h0, "init_rd0");
      expect_v(K_RD1, 32'h0, "init_rd1");
      step();
    end
    expect_v(K_WRDY, 32'h1, "init_wrdy");
    step();

    // Write with same-cycle bypass, then from storage.
    we = 2'b01; set_w(0, 3, 32'hDEAD_BEEF); set_ra(0, 3); set_ra(1, 4);
    expect_v(K_RD0, 32'hDEAD_BEEF, "byp_rd0");
    expect_v(K_RD1, 32'h0, "byp_other");
    step();
    we = 2'b00;
    expect_v(K_RD0, 32'hDEAD_BEEF, "stored_rd0");
    step();

    // Register 0 ignores writes and bypass.
    we = 2'b01; set_w(0, 0, 32'hFFFF_FFFF); set_ra(0, 0);
    expect_v(K_RD0, 32'h0, "x0_same");
    step();
    we = 2'b00;
    expect_v(K_RD0, 32'h0, "x0_after");
    step();

    // Both ports hit register 7: port 1 wins.
    we = 2'b11; set_w(0, 7, 32'h11); set_w(1, 7, 32'h22); set_ra(0, 7); set_ra(1, 7);
    expect_v(K_RD0, 32'h22, "conf_byp0");
    expect_v(K_RD1, 32'h22, "conf_byp1");
    step();
    we = 2'b00;
    expect_v(K_RD0, 32'h22, "conf_stored");
    step();

    // Full clear sequence.
    fill_all();
    set_ra(0, 9); set_ra(1, 31);
    expect_v(K_RD0, 32'd9, "fill_r9");
    expect_v(K_RD1, 32'd31, "fill_r31");
    clr_req = 1'b1;
    expect_v(K_BUSY, 32'h0, "clr_pre_busy");
    step();
    clr_req = 1'b0;
    set_ra(1, 9);
    for (int c = 1; c <= NREG; c++) begin
      if (c == 20) begin
        we = 2'b01; set_w(0, 9, 32'h0000_AAAA); set_ra(0, 9);
        expect_v(K_RD0, 32'h0, "clr_nobyp");
      end else if (c > 20) begin
        we = 2'b00;
        expect_v(K_RD0, 32'h0, "clr_dropped");
      end
      expect_v(K_RD1, (c <= 9) ? 32'd9 : 32'd0, "clr_r9");
      expect_v(K_BUSY, 32'h1, "clr_busy");
      expect_v(K_WRDY, 32'h0, "clr_wrdy");
      expect_v(K_DONE, (c == NREG) ? 32'h1 : 32'h0, "clr_done");
      step();
    end
    we = 2'b00;
    expect_v(K_BUSY, 32'h0, "clr_post_busy");
    expect_v(K_WRDY, 32'h1, "clr_post_wrdy");
    expect_v(K_DONE, 32'h0, "clr_post_done");
    step();
    for (int a = 0; a < NREG; a++) begin
      set_ra(0, a);
      expect_v(K_RD0, 32'h0, "clr_all0");
      step();
    end

    // Reset in the 10th clear cycle aborts the sequence.
    fill_all();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    set_ra(0, 20);
    for (int c = 1; c < 10; c++) begin
      expect_v(K_BUSY, 32'h1, "abort_busy");
      expect_v(K_RD0, 32'd20, "abort_r20");
      step();
    end
    rst = 1'b0;
    expect_v(K_BUSY, 32'h0, "abort_rst_busy");
    expect_v(K_DONE, 32'h0, "abort_rst_done");
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      expect_v(K_DONE, 32'h0, "abort_no_done");
      expect_v(K_WRDY, 32'h1, "abort_wrdy");
      step();
    end
    for (int a = 0; a < NREG; a++) begin
      set_ra(0, a); set_ra(1, NREG - 1 - a);
      expect_v(K_RD0, 32'h0, "abort_all0");
      expect_v(K_RD1, 32'h0, "abort_all1");
      step();
    end

    step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
